lfsr_arbiter: RTL and testbench

- Scheduler/controller that shares one 7-bit random-number LFSR among NUM_REQ requesters.
- Grants requesters round-robin and pulses the LFSR step strobe once per grant.
- Captures the LFSR's one-cycle result and returns it to the granted requester with a one-cycle valid pulse.
- Also sequences seed loading into the LFSR and flags a lost-response timeout.

---
 rtl/lfsr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_lfsr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin scheduler that shares one LFSR among NUM_REQ requesters.
// Define LFSR_ARB_STATS_EN to enable the delivered-word counter on word_count.
module lfsr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 7,
    parameter int TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_val,
    output logic               LFSRiniciar,
    output logic               s_cargar,
    output logic [WIDTH-1:0]   s_valor,
    input  logic [WIDTH-1:0]   LFSRdato,
    input  logic               LFSRvalido,
    output logic [NUM_REQ-1:0] gnt,
    output logic [WIDTH-1:0]   rnd_data,
    output logic [NUM_REQ-1:0] rnd_valid,
    output logic               seed_pend,
    output logic               err,
    output logic [15:0]        word_count
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int SCAN_W = IDX_W + 1;
    localparam int CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEED, STEP, WAIT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [SCAN_W-1:0]  scan;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   seed_q, seed_d;
    logic               iniciar_q, iniciar_d;
    logic               cargar_q, cargar_d;
    logic [WIDTH-1:0]   s_valor_q, s_valor_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [WIDTH-1:0]   rnd_data_q, rnd_data_d;
    logic [NUM_REQ-1:0] rnd_valid_q, rnd_valid_d;
    logic               seed_pend_q, seed_pend_d;
    logic               err_q, err_d;

    // First requesting index at or above rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_ptr_q} + SCAN_W'(i);
            if (scan >= SCAN_W'(NUM_REQ)) begin
                scan = scan - SCAN_W'(NUM_REQ);
            end
            if (!pick_found && req[scan[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        own_d       = own_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        iniciar_d   = 1'b0;
        cargar_d    = 1'b0;
        s_valor_d   = '0;
        gnt_d       = gnt_q;
        rnd_data_d  = rnd_data_q;
        rnd_valid_d = '0;
        seed_pend_d = seed_pend_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (seed_pend_q) begin
                    state_d = SEED;
                end else if (pick_found) begin
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    own_d   = pick_idx;
                    state_d = STEP;
                end
            end
            SEED: begin
                cargar_d    = 1'b1;
                s_valor_d   = seed_q;
                seed_pend_d = 1'b0;
                state_d     = IDLE;
            end
            STEP: begin
                iniciar_d = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (LFSRvalido) begin
                    rnd_data_d  = LFSRdato;
                    rnd_valid_d = gnt_q;
                    rr_ptr_d    = (own_q == IDX_W'(NUM_REQ - 1)) ? '0 : own_q + 1'b1;
                    gnt_d       = '0;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Lost response: pointer stays put so the same requester can retry.
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new seed_load wins over the clear issued by SEED in the same cycle.
        if (seed_load) begin
            seed_d      = seed_val;
            seed_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            own_q       <= '0;
            cnt_q       <= '0;
            seed_q      <= '0;
            iniciar_q   <= 1'b0;
            cargar_q    <= 1'b0;
            s_valor_q   <= '0;
            gnt_q       <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= '0;
            seed_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            own_q       <= own_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            iniciar_q   <= iniciar_d;
            cargar_q    <= cargar_d;
            s_valor_q   <= s_valor_d;
            gnt_q       <= gnt_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
            seed_pend_q <= seed_pend_d;
            err_q       <= err_d;
        end
    end

    assign LFSRiniciar = iniciar_q;
    assign s_cargar    = cargar_q;
    assign s_valor     = s_valor_q;
    assign gnt         = gnt_q;
    assign rnd_data    = rnd_data_q;
    assign rnd_valid   = rnd_valid_q;
    assign seed_pend   = seed_pend_q;
    assign err         = err_q;

`ifdef LFSR_ARB_STATS_EN
    logic [15:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (|rnd_valid_d) begin
            word_count_d = word_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`else
    assign word_count = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter: directed scenarios plus randomized traffic
// against an edge-indexed behavioural model and a 7-bit LFSR environment model.
module tb_lfsr_arbiter;
    localparam int N = 2;
    localparam int W = 7;
    localparam int T = 4;
`ifdef LFSR_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, seed_load, LFSRiniciar, s_cargar, LFSRvalido, seed_pend, err;
    logic [N-1:0] req, gnt, rnd_valid;
    logic [W-1:0] seed_val, s_valor, LFSRdato, rnd_data;
    logic [15:0]  word_count;

    lfsr_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed_val(seed_val),
        .LFSRiniciar(LFSRiniciar), .s_cargar(s_cargar), .s_valor(s_valor),
        .LFSRdato(LFSRdato), .LFSRvalido(LFSRvalido), .gnt(gnt), .rnd_data(rnd_data),
        .rnd_valid(rnd_valid), .seed_pend(seed_pend), .err(err), .word_count(word_count)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Reference model: transactions tracked by the edge number they started on.
    int m_ptr = 0, m_owner = -1, m_grant = 0, m_free = 0, m_seed_edge = -1, m_count = 0;
    bit m_pend = 0, m_err = 0;
    logic [W-1:0] m_seed = '0, m_data = '0;
    logic [N-1:0] e_gnt, e_rvalid;
    logic         e_ini, e_car, e_pend, e_err;
    logic [W-1:0] e_sval, e_rdata;
    logic [15:0]  e_wc;

    logic [W-1:0] lfsr = 7'h01;
    bit suppress = 0, spurious_en = 0;
    logic obs_ini = 1'b0, obs_car = 1'b0;
    logic [W-1:0] obs_sval = '0;
    logic [W-1:0] words[$];
    int owners[$];
    logic [W-1:0] loads[$];

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return {s[W-2:0], s[W-1] ^ s[W-2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            if (mismatched <= 40)
                $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        int chosen;
        e_ini = 1'b0; e_car = 1'b0; e_sval = '0; e_rvalid = '0;
        if (!reset) begin
            m_ptr = 0; m_owner = -1; m_free = cyc + 1; m_seed_edge = -1; m_count = 0;
            m_pend = 0; m_err = 0; m_seed = '0; m_data = '0;
        end else begin
            if (cyc == m_seed_edge) begin
                e_car = 1'b1; e_sval = m_seed; m_pend = 0;
                m_seed_edge = -1; m_free = cyc + 1;
            end
            if (m_owner >= 0) begin
                if (cyc == m_grant + 1) begin
                    e_ini = 1'b1;
                end else if (LFSRvalido) begin
                    e_rvalid = N'(1 << m_owner);
                    m_data = LFSRdato;
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1; m_free = cyc + 1; m_count++;
                end else if (cyc - (m_grant + 1) == T) begin
                    m_err = 1; m_owner = -1; m_free = cyc + 1;
                end
            end else if (cyc == m_free) begin
                if (m_pend) begin
                    m_seed_edge = cyc + 1;
                end else begin
                    chosen = -1;
                    for (int i = 0; i < N; i++) begin
                        int j;
                        j = (m_ptr + i) % N;
                        if (chosen < 0 && ((req >> j) & N'(1)) != 0) chosen = j;
                    end
                    if (chosen >= 0) begin
                        m_owner = chosen; m_grant = cyc;
                    end else begin
                        m_free = cyc + 1;
                    end
                end
            end
            if (seed_load) begin
                m_seed = seed_val; m_pend = 1;
            end
        end
        e_gnt   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_rdata = m_data;
        e_pend  = m_pend;
        e_err   = m_err;
        e_wc    = STATS ? 16'(m_count) : 16'd0;
    endtask

    task automatic runCycle();
        @(posedge clk);
        #1;
        model_edge();
        if (!reset) begin
            lfsr = 7'h01; LFSRvalido = 1'b0; LFSRdato = '0;
        end else if (obs_car) begin
            lfsr = obs_sval; LFSRvalido = 1'b0;
        end else if (obs_ini) begin
            lfsr = lfsr_next(lfsr); LFSRvalido = !suppress; LFSRdato = lfsr;
        end else if (spurious_en && m_owner < 0 && $urandom_range(9) == 0) begin
            LFSRvalido = 1'b1; LFSRdato = W'($urandom);
        end else begin
            LFSRvalido = 1'b0;
        end
        @(negedge clk);
        checkOutput("gnt",        32'(gnt),         32'(e_gnt));
        checkOutput("LFSRiniciar", 32'(LFSRiniciar), 32'(e_ini));
        checkOutput("s_cargar",   32'(s_cargar),    32'(e_car));
        checkOutput("s_valor",    32'(s_valor),     32'(e_sval));
        checkOutput("rnd_data",   32'(rnd_data),    32'(e_rdata));
        checkOutput("rnd_valid",  32'(rnd_valid),   32'(e_rvalid));
        checkOutput("seed_pend",  32'(seed_pend),   32'(e_pend));
        checkOutput("err",        32'(err),         32'(e_err));
        checkOutput("word_count", 32'(word_count),  32'(e_wc));
        obs_ini = LFSRiniciar; obs_car = s_cargar; obs_sval = s_valor;
        if (rnd_valid != '0) begin
            words.push_back(rnd_data);
            for (int b = 0; b < N; b++)
                if (rnd_valid == N'(1 << b)) owners.push_back(b);
        end
        if (s_cargar) loads.push_back(s_valor);
        cyc++;
    endtask

    task automatic applyStimulus();
        for (int b = 0; b < N; b++) begin
            logic [N-1:0] m;
            m = N'(1 << b);
            if ((req & m) != 0 && (rnd_valid & m) != 0) req = req & ~m;
            else if ((req & m) == 0 && $urandom_range(2) == 0) req = req | m;
            else if ((req & m) != 0 && $urandom_range(15) == 0) req = req & ~m;
        end
        seed_load = ($urandom_range(11) == 0);
        seed_val  = W'($urandom);
        suppress  = ($urandom_range(5) == 0);
        reset     = ($urandom_range(299) != 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        runCycle();
        reset = 1'b1;
        words.delete(); owners.delete(); loads.delete();
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int k = 0;
        while (words.size() < n && k < budget) begin runCycle(); k++; end
        checkOutput(tag, 32'(words.size()), 32'(n));
    endtask

    task automatic wait_grant(input string tag);
        int k = 0;
        while (gnt == '0 && k < 15) begin runCycle(); k++; end
        checkOutput(tag, 32'(gnt != '0), 32'd1);
    endtask

    initial begin
        logic [W-1:0] rr_data[4];
        int k;
        rr_data[0] = 7'h02; rr_data[1] = 7'h04; rr_data[2] = 7'h08; rr_data[3] = 7'h10;
        reset = 1'b0; req = '0; seed_load = 1'b0; seed_val = '0;
        LFSRvalido = 1'b0; LFSRdato = '0;
        repeat (2) runCycle();
        reset = 1'b1;

        $display("[TB] single requester after reset");
        req = 2'b01;
        wait_words(1, 20, "first_word_count");
        req = '0;
        if (words.size() > 0) begin
            checkOutput("first_data", 32'(words[0]), 32'h02);
            checkOutput("first_owner", 32'(owners[0]), 32'd0);
        end
        repeat (3) runCycle();

        $display("[TB] two requesters round-robin");
        do_reset();
        req = 2'b11;
        wait_words(4, 40, "rr_word_count");
        req = '0;
        for (int i = 0; i < 4 && i < words.size(); i++) begin
            checkOutput("rr_data", 32'(words[i]), 32'(rr_data[i]));
            checkOutput("rr_owner", 32'(owners[i]), 32'(i % 2));
        end
        repeat (3) runCycle();

        $display("[TB] seed queued during WAIT");
        do_reset();
        req = 2'b10;
        wait_grant("seed_grant");
        runCycle();
        seed_load = 1'b1; seed_val = 7'h55;
        runCycle();
        seed_load = 1'b0;
        wait_words(2, 30, "seed_word_count");
        req = '0;
        checkOutput("seed_load_count", 32'(loads.size()), 32'd1);
        if (loads.size() > 0) checkOutput("seed_value", 32'(loads[0]), 32'h55);
        if (words.size() >= 2) begin
            checkOutput("pre_seed_data", 32'(words[0]), 32'h02);
            checkOutput("post_seed_data", 32'(words[1]), 32'h2B);
            checkOutput("post_seed_owner", 32'(owners[1]), 32'd1);
        end
        repeat (3) runCycle();

        $display("[TB] two seed loads before issue");
        do_reset();
        req = 2'b01;
        wait_grant("dseed_grant");
        runCycle();
        seed_load = 1'b1; seed_val = 7'h11;
        runCycle();
        seed_val = 7'h22;
        runCycle();
        seed_load = 1'b0; req = '0;
        repeat (10) runCycle();
        checkOutput("dseed_count", 32'(loads.size()), 32'd1);
        if (loads.size() > 0) checkOutput("dseed_value", 32'(loads[0]), 32'h22);
        checkOutput("dseed_pend", 32'(seed_pend), 32'd0);

        $display("[TB] lost response timeout");
        do_reset();
        suppress = 1; req = 2'b01;
        wait_grant("to_grant");
        k = 0;
        while (err !== 1'b1 && k < 15) begin runCycle(); k++; end
        checkOutput("timeout_err", 32'(err), 32'd1);
        checkOutput("timeout_no_word", 32'(words.size()), 32'd0);
        wait_grant("to_regrant");
        checkOutput("to_regrant_owner", 32'(gnt), 32'(2'b01));
        suppress = 0;
        wait_words(1, 20, "to_recover_word");
        req = '0;
        repeat (5) runCycle();
        checkOutput("err_sticky", 32'(err), 32'd1);
        do_reset();
        checkOutput("err_cleared", 32'(err), 32'd0);

        $display("[TB] reset during WAIT after five words");
        req = 2'b01;
        wait_words(5, 60, "five_words");
        wait_grant("six_grant");
        runCycle();
        checkOutput("wc_before_reset", 32'(word_count), STATS ? 32'd5 : 32'd0);
        reset = 1'b0;
        runCycle();
        checkOutput("wc_after_reset", 32'(word_count), 32'd0);
        checkOutput("gnt_after_reset", 32'(gnt), 32'd0);
        reset = 1'b1; req = '0;
        repeat (3) runCycle();

        $display("[TB] randomized traffic");
        spurious_en = 1;
        do_reset();
        repeat (2000) begin
            applyStimulus();
            runCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
